// File: rtl/eth_frame_parser.sv
// eth_frame_parser: splits a byte-wide AXI-Stream Ethernet frame into a
// registered header (dest MAC, src MAC, EtherType) and a payload stream.
// Optional feature: define ETH_FRAME_PARSER_TYPE_FILTER_EN to drop every
// frame whose EtherType is neither IPv4 (0x0800) nor ARP (0x0806).
module eth_frame_parser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic                  m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  busy,
    output logic                  error_header_early_termination,
    output logic                  filtered_frame
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [111:0]            hdr_q, hdr_d;
    logic                    hv_q, hv_d;
    logic                    pv_q, pv_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    plast_q, plast_d;
    logic                    puser_q, puser_d;
    logic                    useen_q, useen_d;
    logic                    err_q, err_d;
    logic                    filt_q, filt_d;
    logic                    accept;
    logic                    drop_type;
    logic [111:0]            hdr_next;

    // Header bytes arrive most-significant first, so each new byte shifts in at the bottom.
    assign hdr_next = {hdr_q[103:0], s_axis_tdata[7:0]};
    assign accept   = s_axis_tvalid && s_axis_tready;

`ifdef ETH_FRAME_PARSER_TYPE_FILTER_EN
    assign drop_type = (hdr_next[15:0] != 16'h0800) && (hdr_next[15:0] != 16'h0806);
`else
    assign drop_type = 1'b0;
`endif

    // Input ready: held low in reset, blocked by a pending header, otherwise follows the output register.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE, HEADER: s_axis_tready = !hv_q;
                PAYLOAD:      s_axis_tready = m_eth_payload_axis_tready || !pv_q;
                DROP:         s_axis_tready = 1'b1;
                default:      s_axis_tready = 1'b0;
            endcase
        end
    end

    // Next-state and datapath control for the frame FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        hv_d    = hv_q && !m_eth_hdr_ready;
        pv_d    = pv_q && !m_eth_payload_axis_tready;
        pdata_d = pdata_q;
        plast_d = plast_q;
        puser_d = puser_q;
        useen_d = useen_q;
        err_d   = 1'b0;
        filt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hdr_d   = hdr_next;
                    useen_d = s_axis_tuser;
                    if (s_axis_tlast) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = HEADER;
                    end
                end
            end
            HEADER: begin
                if (accept) begin
                    hdr_d   = hdr_next;
                    useen_d = useen_q || s_axis_tuser;
                    if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else if (cnt_q == 4'd13) begin
                        cnt_d = 4'd0;
                        if (drop_type) begin
                            state_d = DROP;
                        end else begin
                            hv_d    = 1'b1;
                            state_d = PAYLOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    pv_d    = 1'b1;
                    pdata_d = s_axis_tdata;
                    plast_d = s_axis_tlast;
                    // A tuser seen in the header is reported on the frame's final payload byte.
                    puser_d = s_axis_tuser || (s_axis_tlast && useen_q);
                    if (s_axis_tlast) begin
                        useen_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) begin
                    filt_d  = 1'b1;
                    useen_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, header and payload registers; everything clears asynchronously so outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hdr_q   <= '0;
            hv_q    <= 1'b0;
            pv_q    <= 1'b0;
            pdata_q <= '0;
            plast_q <= 1'b0;
            puser_q <= 1'b0;
            useen_q <= 1'b0;
            err_q   <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            hv_q    <= hv_d;
            pv_q    <= pv_d;
            pdata_q <= pdata_d;
            plast_q <= plast_d;
            puser_q <= puser_d;
            useen_q <= useen_d;
            err_q   <= err_d;
            filt_q  <= filt_d;
        end
    end

    assign m_eth_hdr_valid                = hv_q;
    assign m_eth_dest_mac                 = hdr_q[111:64];
    assign m_eth_src_mac                  = hdr_q[63:16];
    assign m_eth_type                     = hdr_q[15:0];
    assign m_eth_payload_axis_tdata       = pdata_q;
    assign m_eth_payload_axis_tkeep       = 1'b1;
    assign m_eth_payload_axis_tvalid      = pv_q;
    assign m_eth_payload_axis_tlast       = plast_q;
    assign m_eth_payload_axis_tuser       = puser_q;
    assign busy                           = (state_q != IDLE);
    assign error_header_early_termination = err_q;
    assign filtered_frame                 = filt_q;

endmodule

// File: tb/tb_eth_frame_parser.sv
// tb_eth_frame_parser: drives directed and random Ethernet frames into
// eth_frame_parser and compares header/payload output against a frame-level
// reference model. Honours ETH_FRAME_PARSER_TYPE_FILTER_EN like the design.
module tb_eth_frame_parser;

`ifdef ETH_FRAME_PARSER_TYPE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        s_tready;
    logic        hv, hr = 1'b1;
    logic [47:0] dest, src;
    logic [15:0] etype;
    logic [7:0]  p_data;
    logic        p_keep, pv, p_last, p_user, pr = 1'b1;
    logic        busy, err_p, filt_p;

    eth_frame_parser #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_eth_hdr_valid(hv), .m_eth_hdr_ready(hr),
        .m_eth_dest_mac(dest), .m_eth_src_mac(src), .m_eth_type(etype),
        .m_eth_payload_axis_tdata(p_data), .m_eth_payload_axis_tkeep(p_keep),
        .m_eth_payload_axis_tvalid(pv), .m_eth_payload_axis_tlast(p_last),
        .m_eth_payload_axis_tuser(p_user), .m_eth_payload_axis_tready(pr),
        .busy(busy), .error_header_early_termination(err_p), .filtered_frame(filt_p)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, acc_cyc = 0, acc13 = 0, hv_rise = -1;
    int obs_pay = 0, obs_err = 0, obs_filt = 0, exp_err = 0, exp_filt = 0;
    int hr_mode = 0, pr_mode = 0;
    bit ignore = 1'b0;
    bit hv_prev = 1'b0, st_hold = 1'b0, hh_hold = 1'b0;
    logic [9:0]   st_val;
    logic [63:0]  hh_val;
    logic [111:0] eh;
    logic [9:0]   ep;
    logic [7:0]   fb[$];
    bit           fu[$];
    logic [111:0] exp_hdr[$];
    logic [9:0]   exp_pay[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame-level reference: decide error/filter/forward and queue what must come out.
    task automatic model_frame();
        int n;
        bit hu;
        logic [111:0] h;
        n  = fb.size();
        hu = 1'b0;
        h  = '0;
        for (int i = 0; i < 14 && i < n; i++) begin
            hu = hu | fu[i];
            h  = {h[103:0], fb[i]};
        end
        if (n <= 14) begin
            exp_err++;
        end else if (FILT && (h[15:0] != 16'h0800) && (h[15:0] != 16'h0806)) begin
            exp_filt++;
        end else begin
            exp_hdr.push_back(h);
            for (int i = 14; i < n; i++)
                exp_pay.push_back({(i == n - 1), fu[i] | ((i == n - 1) & hu), fb[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input logic u, input int gap);
        for (int g = 0; g < gap; g++) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_tdata = b; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                acc_cyc = cyc;
                #1;
                return;
            end
        end
        chk("tready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int gapmax);
        model_frame();
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], (i == fb.size() - 1), fu[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
            if (i == 13) acc13 = acc_cyc;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic set_arp(input logic [47:0] sa);
        logic [335:0] v;
        v = {48'hffffffffffff, sa, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
             sa, 32'hc0a80164, 48'h000000000000, 32'hc0a80165};
        fb.delete(); fu.delete();
        for (int i = 0; i < 42; i++) begin
            fb.push_back(v[335 - 8*i -: 8]);
            fu.push_back(1'b0);
        end
    endtask

    task automatic set_random(input int len, input logic [15:0] t);
        fb.delete(); fu.delete();
        for (int i = 0; i < len; i++) begin
            fb.push_back(8'($urandom));
            fu.push_back($urandom_range(0, 15) == 0);
        end
        if (len > 13) begin
            fb[12] = t[15:8];
            fb[13] = t[7:0];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sink-side ready generators, updated just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        hr = (hr_mode == 0) ? 1'b1 : (hr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        pr = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Output monitor at the falling edge: scoreboard, stall stability, pulse counting.
    always @(negedge clk) begin
        if (!rst && !ignore) begin
            if (hh_hold) chk("hdr_hold", {hv, etype, src[46:0]}, hh_val);
            if (st_hold) chk("pay_stall", {6'd0, pv, p_last, p_user, p_data}, {6'd0, 1'b1, st_val});
            if (hv && hr) begin
                if (exp_hdr.size() == 0) chk("hdr_unexpected", 64'd1, 64'd0);
                else begin
                    eh = exp_hdr.pop_front();
                    chk("hdr_dest", {16'd0, dest}, {16'd0, eh[111:64]});
                    chk("hdr_src",  {16'd0, src},  {16'd0, eh[63:16]});
                    chk("hdr_type", {48'd0, etype}, {48'd0, eh[15:0]});
                end
            end
            if (pv && pr) begin
                if (exp_pay.size() == 0) chk("pay_unexpected", 64'd1, 64'd0);
                else begin
                    ep = exp_pay.pop_front();
                    chk("pay_byte", {54'd0, p_last, p_user, p_data}, {54'd0, ep});
                    obs_pay++;
                end
            end
            if (err_p) obs_err++;
            if (filt_p) obs_filt++;
        end
        hh_hold = !rst && !ignore && hv && !hr;
        hh_val  = {hv, etype, src[46:0]};
        st_hold = !rst && !ignore && pv && !pr;
        st_val  = {p_last, p_user, p_data};
        if (hv && !hv_prev) hv_rise = cyc;
        hv_prev = hv;
        cyc++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, len, pick;
        logic [15:0] t;

        // Reset state, asynchronous and without a clock edge.
        #1 rst = 1'b1;
        #2;
        chk("rst_tready", {63'd0, s_tready}, 64'd0);
        chk("rst_outs", {58'd0, hv, pv, busy, err_p, filt_p, p_last}, 64'd0);
        chk("rst_keep", {63'd0, p_keep}, 64'd1);
        chk("rst_fields", dest ^ src ^ {32'd0, etype} ^ {40'd0, p_data}, 64'd0);
        idle(3);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("tready_after_rst", {63'd0, s_tready}, 64'd1);

        // ARP request, both readies high: header one cycle after byte 13.
        set_arp(48'h5a5152535455);
        base = obs_pay;
        send_frame(0);
        idle(4);
        chk("hdr_latency", 64'(hv_rise), 64'(acc13));
        chk("arp_pay_count", 64'(obs_pay - base), 64'd28);

        // Header held back for 50 cycles while a second frame waits.
        hr_mode = 2; hr = 1'b0;
        base = obs_pay;
        fork
            begin
                set_arp(48'h5a5152535455);
                send_frame(0);
                set_arp(48'h5a5152535499);
                send_frame(0);
            end
            begin
                idle(48);
                chk("stall_tready", {63'd0, s_tready}, 64'd0);
                chk("stall_hv", {63'd0, hv}, 64'd1);
                chk("stall_src", {16'd0, src}, {16'd0, 48'h5a5152535455});
                chk("p1_complete", 64'(obs_pay - base), 64'd28);
                idle(2);
                hr_mode = 0;
            end
        join
        idle(6);

        // Early termination on header byte 9, then a good frame.
        base = obs_err;
        set_random(10, 16'h0800);
        send_frame(0);
        idle(3);
        chk("early_term_pulse", 64'(obs_err - base), 64'd1);
        set_arp(48'h020000000001);
        send_frame(1);
        idle(4);

        // Payload ready toggling randomly.
        pr_mode = 1;
        base = obs_pay;
        set_arp(48'h020000000002);
        send_frame(0);
        idle(8);
        pr_mode = 0;
        idle(3);
        chk("toggle_pay_count", 64'(obs_pay - base), 64'd28);

        // Filtered EtherType.
        base = obs_filt;
        set_random(30, 16'h86dd);
        send_frame(0);
        idle(4);
        chk("filter_pulse", 64'(obs_filt - base), FILT ? 64'd1 : 64'd0);

        // Reset at payload byte 5, then a full frame.
        ignore = 1'b1;
        set_arp(48'h020000000003);
        for (int i = 0; i < 20; i++) send_byte(fb[i], 1'b0, 1'b0, 0);
        #1;
        s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_tready", {63'd0, s_tready}, 64'd0);
        chk("mid_rst_outs", {59'd0, hv, pv, busy, p_last, p_user}, 64'd0);
        chk("mid_rst_data", {56'd0, p_data}, 64'd0);
        idle(3);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        ignore = 1'b0;
        set_arp(48'h020000000004);
        send_frame(0);
        idle(4);

        // Random frames with random gaps, ready patterns, types and tuser.
        for (int f = 0; f < 30; f++) begin
            hr_mode = $urandom_range(0, 1);
            pr_mode = $urandom_range(0, 1);
            len = $urandom_range(8, 60);
            pick = $urandom_range(0, 3);
            t = (pick == 0) ? 16'h0800 : (pick == 1) ? 16'h0806 : (pick == 2) ? 16'h86dd : 16'($urandom);
            set_random(len, t);
            send_frame($urandom_range(0, 2));
        end
        hr_mode = 0; pr_mode = 0;
        idle(20);

        chk("hdr_remaining", 64'(exp_hdr.size()), 64'd0);
        chk("pay_remaining", 64'(exp_pay.size()), 64'd0);
        chk("err_total", 64'(obs_err), 64'(exp_err));
        chk("filt_total", 64'(obs_filt), 64'(exp_filt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
